// File: rtl/gen_toggle_event_detect.sv
// gen_toggle_event_detect
//   Toggle-event source for the toggle-coverage point bank. Each probed bit
//   is handled by one lane. A lane registers rise and fall pulses and keeps
//   that bit's seen mask. The top level handles warm-up, priming and the
//   coverage statistics.
//   Optional build macro: TOGGLE_ONCE_EN. When it is defined, valid reports
//   only first-time events (events whose seen bit was not yet set).

// Per-bit lane: previous sample, edge detect, seen bits, registered pulses.
module gen_toggle_event_detect_lane (
    input  logic gbl_clk,
    input  logic reset,
    input  logic sig,
    input  logic det,       // armed && en for this cycle
    input  logic clr,       // treat seen as empty this cycle
    output logic rise_vld,
    output logic fall_vld,
    output logic rise_new,  // combinational: rise not yet in seen
    output logic fall_new
);
    logic prev;
    logic seen_r, seen_f;
    logic raw_r, raw_f;
    logic base_r, base_f;

    // raw edges against the previous sample, and first-time qualification
    always_comb begin
        raw_r    = det & sig & ~prev;
        raw_f    = det & ~sig & prev;
        base_r   = seen_r & ~clr;
        base_f   = seen_f & ~clr;
        rise_new = raw_r & ~base_r;
        fall_new = raw_f & ~base_f;
    end

    // prev follows sig on every non-reset cycle so re-enabling never sees stale edges
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev     <= 1'b0;
            seen_r   <= 1'b0;
            seen_f   <= 1'b0;
            rise_vld <= 1'b0;
            fall_vld <= 1'b0;
        end else begin
            prev     <= sig;
            seen_r   <= base_r | raw_r;
            seen_f   <= base_f | raw_f;
`ifdef TOGGLE_ONCE_EN
            rise_vld <= rise_new;
            fall_vld <= fall_new;
`else
            rise_vld <= raw_r;
            fall_vld <= raw_f;
`endif
        end
    end
endmodule

module gen_toggle_event_detect #(
    parameter int WIDTH  = 23,
    parameter int WARMUP = 4,
    localparam int NB    = 2 * WIDTH,
    localparam int CW    = $clog2(NB + 1)
) (
    input  logic          gbl_clk,
    input  logic          reset,
    input  logic [WIDTH-1:0] sig,
    input  logic          en,
    input  logic          clr_seen,
    output logic [NB-1:0] valid,
    output logic [CW-1:0] new_hits,
    output logic [CW-1:0] covered_cnt,
    output logic          all_covered
);
    localparam logic [7:0] WARM_LIM = 8'(WARMUP);

    logic          primed;
    logic [7:0]    warm;
    logic          armed;
    logic          det;
    logic [NB-1:0] new_vec;
    logic [CW-1:0] hits_nxt;
    logic [CW-1:0] covered_nxt;

    function automatic logic [CW-1:0] popcnt(input logic [NB-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NB; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    gen_toggle_event_detect_lane u_lane [WIDTH-1:0] (
        .gbl_clk  (gbl_clk),
        .reset    (reset),
        .sig      (sig),
        .det      (det),
        .clr      (clr_seen),
        .rise_vld (valid[WIDTH-1:0]),
        .fall_vld (valid[NB-1:WIDTH]),
        .rise_new (new_vec[WIDTH-1:0]),
        .fall_new (new_vec[NB-1:WIDTH])
    );

    // arming and the next coverage statistics
    always_comb begin
        armed       = primed && (warm == WARM_LIM);
        det         = armed && en;
        hits_nxt    = popcnt(new_vec);
        covered_nxt = clr_seen ? hits_nxt : covered_cnt + hits_nxt;
    end

    // first sample only primes; warm-up counts the cycles after priming
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            primed <= 1'b0;
            warm   <= 8'd0;
        end else begin
            primed <= 1'b1;
            if (primed && warm < WARM_LIM) warm <= warm + 8'd1;
        end
    end

    // statistics registered alongside the valid pulses
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            new_hits    <= '0;
            covered_cnt <= '0;
            all_covered <= 1'b0;
        end else begin
            new_hits    <= hits_nxt;
            covered_cnt <= covered_nxt;
            all_covered <= (covered_nxt == CW'(NB));
        end
    end
endmodule
